mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage requester that sits directly upstream of the data bus.
- Takes one load/store per instruction from the pipeline MEM stage and drives the bus strobes, address and write data.
- Holds the pipeline stalled until the addressed device signals DataDone, or until a timeout expires.
- Returns load data to writeback and guarantees strobes drop for one cycle between accesses, so toggling done-generators rearm cleanly.

Parameters:
- DATA_W, 16, data width of bus and pipeline.
- ADDR_W, 16, address width; [15:12] selects the device.
- TIMEOUT, 255, maximum ACCESS-state cycles before an access is aborted (1..65535).
- ERR_DATA, 16'hDEAD, value returned as rdata on a timed-out load.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  MEM stage holds a memory op this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte/word address of the op.
- req_wdata  in  DATA_W  store data.
- stall  out  1  pipeline must hold its MEM/WB registers.
- resp_valid  out  1  one-cycle pulse; access complete.
- resp_rdata  out  DATA_W  load data; valid with resp_valid.
- resp_err  out  1  with resp_valid: access timed out.
- ReadData  out  1  bus read strobe (registered).
- WriteData  out  1  bus write strobe (registered).
- DataAddr  out  ADDR_W  bus address (registered).
- BusIn  out  DATA_W  bus write data (registered).
- BusOut  in  DATA_W  bus read data.
- DataDone  in  1  device completion.

Behaviour:
- Reset (async, any time, including mid-access):
  - state = IDLE.
  - ReadData, WriteData, resp_valid and resp_err = 0.
  - DataAddr, BusIn and resp_rdata = 0.
  - timeout counter = 0.
  - No partial response is produced after reset releases.
- FSM states: IDLE, ACCESS, RELEASE.
- IDLE:
  - Strobes are 0.
  - If req_valid: latch req_addr to DataAddr and req_wdata to BusIn.
  - Set WriteData = req_write and ReadData = ~req_write. Exactly one strobe is ever high.
  - Clear the counter and go to ACCESS.
- ACCESS:
  - Strobes are held and the counter increments each cycle.
  - If DataDone = 1: on that edge capture BusOut into resp_rdata (loads only; stores leave resp_rdata unchanged), clear both strobes, and go to RELEASE.
  - Else if counter == TIMEOUT-1: clear strobes, set resp_rdata = ERR_DATA (loads) and resp_err = 1, and go to RELEASE.
  - DataDone has priority over timeout in the same cycle.
- RELEASE:
  - Lasts exactly 1 cycle with strobes 0.
  - resp_valid = 1; resp_err is valid.
  - Next state is IDLE. resp_valid and resp_err are cleared the following cycle.
- stall (combinational):
  - 1 when (state == IDLE and req_valid) or state == ACCESS.
  - 0 in RELEASE and when IDLE with no request.
  - The pipeline advances at the end of RELEASE, so a request is never accepted twice.
- DataDone seen in IDLE or RELEASE is ignored.
- Latency with a device whose done asserts one edge after the strobe:
  - Request in cycle 0; strobe high in cycles 1–2; resp_valid in cycle 3.
  - 3 stall cycles, then 1 unstalled cycle.
- Back-to-back ops: the minimum gap between strobe assertions is 2 cycles (RELEASE plus IDLE-accept).
- A store held through the DataDone cycle may be written twice with identical address and data; this is permitted.
- Address and data outputs hold their last value while idle.

Test Plan:
- Load from memory device: memory[0x0010] = 16'h1234, req load at 16'h0010.
  - ReadData high cycles 1–2, DataAddr = 16'h0010.
  - resp_valid cycle 3 with resp_rdata = 16'h1234, resp_err = 0.
  - stall high cycles 0–2, low cycle 3.
- Store then load: store 16'hBEEF to 16'h0020, then load 16'h0020.
  - WriteData high with BusIn = 16'hBEEF.
  - Strobes low ≥1 cycle between ops.
  - Load returns 16'hBEEF.
- Slow device: request to 16'h1002; DataDone asserted 6 cycles after strobe with BusOut = 16'h3C00.
  - stall high throughout; resp_rdata = 16'h3C00.
  - Exactly one resp_valid pulse.
- Timeout: TIMEOUT = 8, DataDone tied 0, load 16'h7000.
  - Strobe high exactly 8 cycles.
  - resp_valid with resp_err = 1, resp_rdata = 16'hDEAD.
  - FSM returns to IDLE.
- Reset mid-access: assert Reset asynchronously 2 cycles into ACCESS.
  - ReadData/WriteData fall immediately and resp_valid never pulses.
  - After release, a new load completes normally.
- Done/timeout collision: TIMEOUT = 4, DataDone asserted in the 4th ACCESS cycle with BusOut = 16'h00AA.
  - resp_err = 0, resp_rdata = 16'h00AA.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage bus requester: one strobed load/store per MEM-stage op,
// stalls the pipeline until DataDone or timeout, then a one-cycle release.
module mem_stage_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = 16'hDEAD
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              ReadData,
    output logic              WriteData,
    output logic [ADDR_W-1:0] DataAddr,
    output logic [DATA_W-1:0] BusIn,
    input  logic [DATA_W-1:0] BusOut,
    input  logic              DataDone
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rv_q, rv_d;
    logic              re_q, re_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        bin_d   = bin_q;
        rdata_d = rdata_q;
        rv_d    = 1'b0;
        re_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    bin_d   = req_wdata;
                    wr_d    = req_write;
                    rd_d    = ~req_write;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + 16'd1;
                // Completion wins over a timeout landing on the same cycle.
                if (DataDone) begin
                    if (rd_q) rdata_d = BusOut;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rv_d    = 1'b1;
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    if (rd_q) rdata_d = ERR_DATA;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rv_d    = 1'b1;
                    re_d    = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            bin_q   <= '0;
            rdata_q <= '0;
            rv_q    <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            bin_q   <= bin_d;
            rdata_q <= rdata_d;
            rv_q    <= rv_d;
            re_q    <= re_d;
        end
    end

    assign stall      = (state_q == S_ACCESS) |
                        ((state_q == S_IDLE) & req_valid);
    assign resp_valid = rv_q;
    assign resp_err   = re_q;
    assign resp_rdata = rdata_q;
    assign ReadData   = rd_q;
    assign WriteData  = wr_q;
    assign DataAddr   = addr_q;
    assign BusIn      = bin_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: three instances (TIMEOUT 255/8/4), a per-cycle
// reference model and directed pipeline-style operations.
module tb_mem_stage_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  req_valid = '0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic [15:0] BusOut    = '0;
    logic [2:0]  done_v    = '0;

    logic [2:0]  stall_o, rv_o, re_o, rd_o, wr_o;
    logic [15:0] rdata_o [3];
    logic [15:0] addr_o  [3];
    logic [15:0] bin_o   [3];

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    mem_stage_ctrl #(.TIMEOUT(255)) dut0 (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall_o[0]), .resp_valid(rv_o[0]),
        .resp_rdata(rdata_o[0]), .resp_err(re_o[0]),
        .ReadData(rd_o[0]), .WriteData(wr_o[0]),
        .DataAddr(addr_o[0]), .BusIn(bin_o[0]),
        .BusOut(BusOut), .DataDone(done_v[0])
    );

    mem_stage_ctrl #(.TIMEOUT(8)) dut1 (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall_o[1]), .resp_valid(rv_o[1]),
        .resp_rdata(rdata_o[1]), .resp_err(re_o[1]),
        .ReadData(rd_o[1]), .WriteData(wr_o[1]),
        .DataAddr(addr_o[1]), .BusIn(bin_o[1]),
        .BusOut(BusOut), .DataDone(done_v[1])
    );

    mem_stage_ctrl #(.TIMEOUT(4)) dut2 (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid[2]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall_o[2]), .resp_valid(rv_o[2]),
        .resp_rdata(rdata_o[2]), .resp_err(re_o[2]),
        .ReadData(rd_o[2]), .WriteData(wr_o[2]),
        .DataAddr(addr_o[2]), .BusIn(bin_o[2]),
        .BusOut(BusOut), .DataDone(done_v[2])
    );

    // Reference model: an access in flight, its age in strobe cycles,
    // and a pending one-cycle response.
    int          m_limit [3] = '{255, 8, 4};
    bit          m_busy  [3];
    bit          m_wr    [3];
    bit          m_resp  [3];
    bit          m_err   [3];
    int          m_age   [3];
    logic [15:0] m_addr  [3];
    logic [15:0] m_bin   [3];
    logic [15:0] m_rdata [3];

    always @(posedge Clock or posedge Reset) begin
        for (int i = 0; i < 3; i++) begin
            if (Reset) begin
                m_busy[i] = 0; m_wr[i] = 0; m_resp[i] = 0; m_err[i] = 0;
                m_age[i] = 0; m_addr[i] = '0; m_bin[i] = '0;
                m_rdata[i] = '0;
            end else if (m_resp[i]) begin
                m_resp[i] = 0;
                m_err[i]  = 0;
            end else if (m_busy[i]) begin
                m_age[i] = m_age[i] + 1;
                if (done_v[i]) begin
                    m_busy[i] = 0; m_resp[i] = 1; m_err[i] = 0;
                    if (!m_wr[i]) m_rdata[i] = BusOut;
                end else if (m_age[i] == m_limit[i]) begin
                    m_busy[i] = 0; m_resp[i] = 1; m_err[i] = 1;
                    if (!m_wr[i]) m_rdata[i] = 16'hDEAD;
                end
            end else if (req_valid[i]) begin
                m_busy[i] = 1;
                m_age[i]  = 0;
                m_wr[i]   = req_write;
                m_addr[i] = req_addr;
                m_bin[i]  = req_wdata;
            end
        end
    end

    always @(negedge Clock) begin
        for (int i = 0; i < 3; i++) begin
            logic [4:0]  ec, ac;
            logic [47:0] ed, ad;
            ec = {m_busy[i] & !m_wr[i], m_busy[i] & m_wr[i],
                  m_busy[i] | (!m_resp[i] & req_valid[i]),
                  m_resp[i], m_resp[i] & m_err[i]};
            ac = {rd_o[i], wr_o[i], stall_o[i], rv_o[i], re_o[i]};
            ed = {m_addr[i], m_bin[i], m_rdata[i]};
            ad = {addr_o[i], bin_o[i], rdata_o[i]};
            checks++;
            if (ec !== ac || ed !== ad) begin
                errors++;
                $display("FAIL model dut%0d t=%0t rd/wr/stall/rv/err=%b need %b addr/bin/rdata=%h need %h",
                         i, $time, ac, ec, ad, ed);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          n;
        logic [31:0] stall_v;
        logic [31:0] rd_v;
        logic [31:0] wr_v;
        int          rv_cnt;
        logic [15:0] rdata;
        logic        err;
        logic [15:0] addr;
        logic [15:0] bin;
    } res_t;

    // One pipeline op: request held until a cycle with stall low.
    // dly = edges after the strobe rises at which DataDone pulses (<0: never).
    task automatic do_op(input int sel, input logic wr,
                         input logic [15:0] a, input logic [15:0] wd,
                         input int dly, input logic [15:0] bo,
                         output res_t r);
        int k;
        bit fin;
        r = '{0, '0, '0, '0, 0, '0, 1'b0, '0, '0};
        @(posedge Clock); #1;
        req_valid[sel] = 1'b1;
        req_write = wr; req_addr = a; req_wdata = wd; BusOut = bo;
        k = 0; fin = 0;
        while (!fin && k < 300) begin
            done_v[sel] = (dly >= 0) && (k == 1 + dly);
            @(negedge Clock);
            if (k < 32) begin
                r.stall_v[k] = stall_o[sel];
                r.rd_v[k]    = rd_o[sel];
                r.wr_v[k]    = wr_o[sel];
            end
            if (rd_o[sel] | wr_o[sel]) begin
                r.addr = addr_o[sel];
                r.bin  = bin_o[sel];
            end
            if (rv_o[sel]) begin
                r.rv_cnt++;
                r.rdata = rdata_o[sel];
                r.err   = re_o[sel];
            end
            if (!stall_o[sel]) fin = 1;
            @(posedge Clock); #1;
            k++;
        end
        req_valid[sel] = 1'b0;
        done_v[sel] = 1'b0;
        r.n = k;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL op_complete dut%0d got stall-cycles %0d expected <300", sel, k);
        end
    endtask

    initial begin
        res_t r;
        int pulses;

        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        chk("reset_strobes", {30'd0, rd_o[0], wr_o[0]}, 32'd0);
        chk("reset_resp", {30'd0, rv_o[0], re_o[0]}, 32'd0);
        chk("reset_addr", {16'd0, addr_o[0]}, 32'd0);
        chk("reset_rdata", {16'd0, rdata_o[0]}, 32'd0);

        // Load from a device that answers one edge after the strobe
        do_op(0, 1'b0, 16'h0010, 16'h0000, 1, 16'h1234, r);
        chk("load_rd_cycles", r.rd_v, 32'h0000_0006);
        chk("load_stall_cycles", r.stall_v, 32'h0000_0007);
        chk("load_len", r.n, 4);
        chk("load_addr", {16'd0, r.addr}, 32'h0010);
        chk("load_rv_cnt", r.rv_cnt, 1);
        chk("load_rdata", {16'd0, r.rdata}, 32'h1234);
        chk("load_err", {31'd0, r.err}, 32'd0);

        // Store then load back
        do_op(0, 1'b1, 16'h0020, 16'hBEEF, 1, 16'h0000, r);
        chk("store_wr_cycles", r.wr_v, 32'h0000_0006);
        chk("store_rd_cycles", r.rd_v, 32'h0000_0000);
        chk("store_bin", {16'd0, r.bin}, 32'hBEEF);
        chk("store_addr", {16'd0, r.addr}, 32'h0020);
        chk("store_keeps_rdata", {16'd0, rdata_o[0]}, 32'h1234);
        do_op(0, 1'b0, 16'h0020, 16'h0000, 1, 16'hBEEF, r);
        chk("ld_after_st_gap", {31'd0, r.rd_v[0]}, 32'd0);
        chk("ld_after_st_rdata", {16'd0, r.rdata}, 32'hBEEF);

        // Slow device: done six edges after the strobe
        do_op(0, 1'b0, 16'h1002, 16'h0000, 6, 16'h3C00, r);
        chk("slow_rd_cycles", r.rd_v, 32'h0000_00FE);
        chk("slow_stall_cycles", r.stall_v, 32'h0000_00FF);
        chk("slow_rv_cnt", r.rv_cnt, 1);
        chk("slow_rdata", {16'd0, r.rdata}, 32'h3C00);

        // Timeout with TIMEOUT = 8
        do_op(1, 1'b0, 16'h7000, 16'h0000, -1, 16'h1111, r);
        chk("to_rd_cycles", r.rd_v, 32'h0000_01FE);
        chk("to_rv_cnt", r.rv_cnt, 1);
        chk("to_err", {31'd0, r.err}, 32'd1);
        chk("to_rdata", {16'd0, r.rdata}, 32'hDEAD);
        @(negedge Clock);
        chk("to_idle", {29'd0, stall_o[1], rd_o[1], rv_o[1]}, 32'd0);
        do_op(1, 1'b0, 16'h7002, 16'h0000, 1, 16'h5555, r);
        chk("to_recover_rdata", {16'd0, r.rdata}, 32'h5555);
        chk("to_recover_err", {31'd0, r.err}, 32'd0);

        // Done and timeout on the same cycle (TIMEOUT = 4)
        do_op(2, 1'b0, 16'h3000, 16'h0000, 3, 16'h00AA, r);
        chk("coll_rd_cycles", r.rd_v, 32'h0000_001E);
        chk("coll_err", {31'd0, r.err}, 32'd0);
        chk("coll_rdata", {16'd0, r.rdata}, 32'h00AA);
        do_op(2, 1'b1, 16'h3004, 16'h7777, -1, 16'h0000, r);
        chk("to4_wr_cycles", r.wr_v, 32'h0000_001E);
        chk("to4_store_err", {31'd0, r.err}, 32'd1);
        chk("to4_store_rdata", {16'd0, r.rdata}, 32'h00AA);

        // DataDone while idle is ignored
        @(posedge Clock); #1 done_v[0] = 1'b1; BusOut = 16'hFFFF;
        @(negedge Clock);
        @(posedge Clock); #1 done_v[0] = 1'b0;
        @(negedge Clock);
        chk("idle_done_rv", {31'd0, rv_o[0]}, 32'd0);
        chk("idle_done_rdata", {16'd0, rdata_o[0]}, 32'h3C00);

        // Reset two cycles into an access
        @(posedge Clock); #1;
        req_valid[0] = 1'b1; req_write = 1'b0; req_addr = 16'h0040;
        @(posedge Clock);
        @(posedge Clock); #2;
        chk("rst_mid_rd_before", {31'd0, rd_o[0]}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("rst_mid_strobes", {30'd0, rd_o[0], wr_o[0]}, 32'd0);
        chk("rst_mid_addr", {16'd0, addr_o[0]}, 32'd0);
        req_valid[0] = 1'b0;
        @(posedge Clock); #1 Reset = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge Clock);
            pulses += int'(rv_o[0]);
        end
        chk("rst_mid_no_resp", pulses, 0);
        do_op(0, 1'b0, 16'h0042, 16'h0000, 1, 16'h4242, r);
        chk("rst_after_rdata", {16'd0, r.rdata}, 32'h4242);
        chk("rst_after_rv_cnt", r.rv_cnt, 1);

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
